// File: rtl/hdmi_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the HDMI pixel path: 640x480 timing sizes, the
// default sync polarity, RGB width, default source image geometry, the
// bundle of per-pixel control bits that travels alongside the ROM data, and
// the ROM-word to RGB expansion helper.
// -----------------------------------------------------------------------------
package hdmi_pkg;

    // 640x480 @ 60 Hz raster
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    // Sync pulses are active low in the 640x480 mode
    localparam logic SYNC_POL_DEF = 1'b0;

    localparam int RGB_W = 24;

    // Default source image: 320x240 shown with 2x2 pixel replication
    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int SCALE_DEF = 1;

    // Control bits that must stay cycle-aligned with the pixel data
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic in_img;
        logic frame_pulse;
    } px_ctrl_t;

    localparam int PX_CTRL_W = $bits(px_ctrl_t);

    // Turn a ROM word into {R,G,B}: greyscale ROMs only carry a luma byte
    function automatic logic [RGB_W-1:0] expand_px(input logic [RGB_W-1:0] d,
                                                   input logic             mono);
        return mono ? {3{d[7:0]}} : d;
    endfunction

endpackage

// File: rtl/hdmi_px_fetch_sig_delay.sv
// -----------------------------------------------------------------------------
// sig_delay
// Fixed-length shift register with a programmable reset pattern. Every stage
// is loaded with RST_VAL on reset so the output shows idle levels until real
// data has propagated through.
//
// Ports
//   i_clk    in   1      clock
//   i_rst_n  in   1      asynchronous active-low reset
//   i_d      in   WIDTH  data in
//   o_q      out  WIDTH  data in delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [DEPTH-1:0][WIDTH-1:0] w_shift;

    // Next value of each stage: stage 0 takes the input, others the stage before
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_shift[gi] = i_d;
            end else begin : g_body
                assign w_shift[gi] = r_stage[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= {DEPTH{RST_VAL}};
        end else begin
            r_stage <= w_shift;
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/hdmi_px_fetch.sv
// -----------------------------------------------------------------------------
// hdmi_px_fetch
// Pixel fetch and alignment stage between the HDMI timing generator and the
// transmitter. Tracks the raw DE/HS/VS stream, produces image ROM addresses
// with 2^SCALE integer upscaling, expands ROM data to 24-bit RGB (optional
// mono replication and inversion, BORDER outside the image) and delays the
// timing so that sync, DE and pixels leave aligned, ROM_LAT+2 clocks after
// the raw timing.
//
// Ports
//   i_clk_px       in   1           pixel clock
//   i_rst_n        in   1           asynchronous active-low reset
//   i_de           in   1           raw data enable
//   i_hs           in   1           raw horizontal sync
//   i_vs           in   1           raw vertical sync
//   i_inv          in   1           invert image pixels (not the border)
//   i_px_data      in   24          ROM read data
//   o_px_addr      out  ADDR_WIDTH  ROM read address (registered)
//   o_de           out  1           aligned data enable
//   o_hsync        out  1           aligned horizontal sync
//   o_vsync        out  1           aligned vertical sync
//   o_red/green/blue out 8 each     aligned pixel data
//   o_frame_start  out  1           pulse with the first DE of a frame
// -----------------------------------------------------------------------------
module hdmi_px_fetch
    import hdmi_pkg::*;
#(
    parameter int              IMG_W      = IMG_W_DEF,
    parameter int              IMG_H      = IMG_H_DEF,
    parameter int              SCALE      = SCALE_DEF,
    parameter int              ADDR_WIDTH = 19,
    parameter int              ROM_LAT    = 2,
    parameter int              MONO       = 1,
    parameter logic            SYNC_POL   = SYNC_POL_DEF,
    parameter logic [RGB_W-1:0] BORDER    = 24'h000000
) (
    input  logic                  i_clk_px,
    input  logic                  i_rst_n,
    input  logic                  i_de,
    input  logic                  i_hs,
    input  logic                  i_vs,
    input  logic                  i_inv,
    input  logic [RGB_W-1:0]      i_px_data,
    output logic [ADDR_WIDTH-1:0] o_px_addr,
    output logic                  o_de,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic [7:0]            o_red,
    output logic [7:0]            o_green,
    output logic [7:0]            o_blue,
    output logic                  o_frame_start
);

    localparam int CNT_W = 16;

    // Sub-pixel counters wrap at 2^SCALE-1; kept CNT_W wide so SCALE=0 works
    localparam logic [CNT_W-1:0]      SUB_MAX  = CNT_W'((1 << SCALE) - 1);
    localparam logic [CNT_W-1:0]      IMG_W_C  = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]      IMG_H_C  = CNT_W'(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);

    // Delay-line reset pattern: DE low, syncs inactive, no image, no pulse
    localparam logic [PX_CTRL_W-1:0] CTRL_RST = {1'b0, ~SYNC_POL, ~SYNC_POL, 2'b00};

    // ---------------------------------------------------------------------
    // Input edge detection
    // ---------------------------------------------------------------------
    logic r_de_d;
    logic r_vs_act_d;
    logic r_armed;

    logic w_vs_act;
    logic w_vs_edge;
    logic w_de_rise;
    logic w_de_fall;
    logic w_frame_pulse;

    assign w_vs_act  = (i_vs == SYNC_POL);
    assign w_vs_edge = w_vs_act & ~r_vs_act_d;
    assign w_de_rise = i_de & ~r_de_d;
    assign w_de_fall = ~i_de & r_de_d;

    // First DE rise after a VS edge (or on the same cycle as one)
    assign w_frame_pulse = w_de_rise & (r_armed | w_vs_edge);

    always_ff @(posedge i_clk_px or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_de_d     <= 1'b0;
            r_vs_act_d <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_de_d     <= i_de;
            r_vs_act_d <= w_vs_act;
            r_armed    <= (r_armed | w_vs_edge) & ~w_frame_pulse;
        end
    end

    // ---------------------------------------------------------------------
    // Screen (horizontal) counters
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] r_x_sub;
    logic [CNT_W-1:0] r_col;

    always_ff @(posedge i_clk_px or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_sub <= '0;
            r_col   <= '0;
        end else if (w_de_fall) begin
            r_x_sub <= '0;
            r_col   <= '0;
        end else if (i_de) begin
            if (r_x_sub == SUB_MAX) begin
                r_x_sub <= '0;
                r_col   <= r_col + CNT_W'(1);
            end else begin
                r_x_sub <= r_x_sub + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Line counters. row_base tracks row*IMG_W by accumulation so the address
    // path needs only an adder. A VS edge wins over a coincident DE fall.
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0]      r_y_sub;
    logic [CNT_W-1:0]      r_row;
    logic [ADDR_WIDTH-1:0] r_row_base;

    always_ff @(posedge i_clk_px or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y_sub    <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (w_vs_edge) begin
            r_y_sub    <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (w_de_fall) begin
            if (r_y_sub == SUB_MAX) begin
                r_y_sub <= '0;
                // Saturate once the image is exhausted: stays at IMG_H rows
                if (r_row < IMG_H_C) begin
                    r_row      <= r_row + CNT_W'(1);
                    r_row_base <= r_row_base + ROW_STEP;
                end
            end else begin
                r_y_sub <= r_y_sub + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Address register
    // ---------------------------------------------------------------------
    logic                  w_in_img;
    logic [ADDR_WIDTH-1:0] r_px_addr;

    assign w_in_img = i_de & (r_col < IMG_W_C) & (r_row < IMG_H_C);

    always_ff @(posedge i_clk_px or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_px_addr <= '0;
        end else if (w_in_img) begin
            r_px_addr <= r_row_base + ADDR_WIDTH'(r_col);
        end else begin
            r_px_addr <= '0;
        end
    end

    assign o_px_addr = r_px_addr;

    // ---------------------------------------------------------------------
    // Control delay line: covers the address register plus the ROM latency,
    // so its output lines up with the ROM data entering the output register.
    // ---------------------------------------------------------------------
    px_ctrl_t w_ctrl_in;
    px_ctrl_t w_ctrl_dly;

    always_comb begin
        w_ctrl_in             = '0;
        w_ctrl_in.de          = i_de;
        w_ctrl_in.hs          = i_hs;
        w_ctrl_in.vs          = i_vs;
        w_ctrl_in.in_img      = w_in_img;
        w_ctrl_in.frame_pulse = w_frame_pulse;
    end

    sig_delay #(
        .WIDTH   (PX_CTRL_W),
        .DEPTH   (ROM_LAT + 1),
        .RST_VAL (CTRL_RST)
    ) u_ctrl_dly (
        .i_clk   (i_clk_px),
        .i_rst_n (i_rst_n),
        .i_d     (w_ctrl_in),
        .o_q     (w_ctrl_dly)
    );

    // ---------------------------------------------------------------------
    // Output register: colour selection, inversion applies to image only
    // ---------------------------------------------------------------------
    logic [RGB_W-1:0] w_img_px;
    logic [RGB_W-1:0] w_rgb_next;

    logic [RGB_W-1:0] r_rgb;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    assign w_img_px = expand_px(i_px_data, MONO != 0) ^ {RGB_W{i_inv}};

    always_comb begin
        w_rgb_next = '0;
        if (w_ctrl_dly.de) begin
            w_rgb_next = w_ctrl_dly.in_img ? w_img_px : BORDER;
        end
    end

    always_ff @(posedge i_clk_px or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb_next;
            r_de          <= w_ctrl_dly.de;
            r_hsync       <= w_ctrl_dly.hs;
            r_vsync       <= w_ctrl_dly.vs;
            r_frame_start <= w_ctrl_dly.frame_pulse;
        end
    end

    assign o_red         = r_rgb[23:16];
    assign o_green       = r_rgb[15:8];
    assign o_blue        = r_rgb[7:0];
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_hdmi_px_fetch.sv
// -----------------------------------------------------------------------------
// tb_hdmi_px_fetch
// Drives a reduced raster (100x50 active) into a 40x20 image at 2x scale,
// with random horizontal blanking and random INV toggles. A ROM model feeds
// data back. Expected outputs come from a screen-coordinate model: the image
// pixel for a cycle is ((y>>SCALE)*IMG_W + (x>>SCALE)) where x counts DE
// cycles in the line and y counts lines since the last VS edge or reset.
// -----------------------------------------------------------------------------
module tb_hdmi_px_fetch;
    import hdmi_pkg::*;

    localparam int IMG_W   = 40;
    localparam int IMG_H   = 20;
    localparam int SCALE   = 1;
    localparam int AW      = 19;
    localparam int ROM_LAT = 2;
    localparam int LAT     = ROM_LAT + 2;
    localparam logic [23:0] BORDER = 24'h3C5A96;

    localparam int H_ACT = 100;
    localparam int V_ACT = 50;
    localparam int V_TOT = 54;
    localparam int NCYC  = 40000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          de_in = 1'b0;
    logic          hs_in = 1'b1;
    logic          vs_in = 1'b1;
    logic          inv = 1'b0;
    logic [23:0]   px_data;
    logic [AW-1:0] px_addr;
    logic          de_o, hs_o, vs_o, fs_o;
    logic [7:0]    red, green, blue;

    always #5 clk = ~clk;

    hdmi_px_fetch #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .SCALE      (SCALE),
        .ADDR_WIDTH (AW),
        .ROM_LAT    (ROM_LAT),
        .MONO       (1),
        .SYNC_POL   (1'b0),
        .BORDER     (BORDER)
    ) dut (
        .i_clk_px      (clk),
        .i_rst_n       (rst_n),
        .i_de          (de_in),
        .i_hs          (hs_in),
        .i_vs          (vs_in),
        .i_inv         (inv),
        .i_px_data     (px_data),
        .o_px_addr     (px_addr),
        .o_de          (de_o),
        .o_hsync       (hs_o),
        .o_vsync       (vs_o),
        .o_red         (red),
        .o_green       (green),
        .o_blue        (blue),
        .o_frame_start (fs_o)
    );

    // ROM model: data for an address appears ROM_LAT clocks after it; upper
    // bytes carry unrelated values so mono replication is exercised
    logic [AW-1:0] rom_q [ROM_LAT];
    always @(posedge clk) begin
        rom_q[0] <= px_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
    end
    assign px_data = {rom_q[ROM_LAT-1][7:0] ^ 8'hA5, ~rom_q[ROM_LAT-1][7:0], rom_q[ROM_LAT-1][7:0]};

    // Per-cycle history of stimulus and model results
    bit            h_de  [NCYC];
    bit            h_hs  [NCYC];
    bit            h_vs  [NCYC];
    bit            h_img [NCYC];
    bit            h_fs  [NCYC];
    bit            h_inv [NCYC];
    logic [AW-1:0] h_addr[NCYC];

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_rst = -1;
    int    fs_cnt = 0;
    int    mx = 0, my = 0;
    bit    prev_de = 0, prev_vs = 0, armed = 0;
    bit    pend_v = 0;
    int    pend_exp = 0;
    string pend_tag = "";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    // One pixel clock: drive inputs, update the model, check the outputs
    task automatic drive(input bit r, input bit de, input bit hs, input bit vs,
                         input bit spot_v, input int spot_exp, input string spot_tag);
        bit            vs_act, de_rise, de_fall, vs_edge, img, fs;
        logic [AW-1:0] a;
        logic [23:0]   e_rgb;
        logic [7:0]    b;
        bit            e_de, e_hs, e_vs, e_fs;
        int            s;
        @(posedge clk);
        #1;
        if (cyc >= NCYC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
            $fatal(1, "cycle budget exceeded");
        end
        rst_n = !r;
        de_in = de;
        hs_in = hs;
        vs_in = vs;
        if ($urandom_range(0, 19) == 0) inv = ~inv;
        h_inv[cyc] = inv;
        h_hs[cyc]  = hs;
        h_vs[cyc]  = vs;
        if (r) begin
            last_rst = cyc;
            mx = 0; my = 0; prev_de = 0; prev_vs = 0; armed = 0;
            h_de[cyc] = 0; h_img[cyc] = 0; h_fs[cyc] = 0; h_addr[cyc] = '0;
        end else begin
            vs_act  = (vs == 1'b0);
            de_rise = de && !prev_de;
            de_fall = !de && prev_de;
            vs_edge = vs_act && !prev_vs;
            img = de && ((mx >> SCALE) < IMG_W) && ((my >> SCALE) < IMG_H);
            a   = img ? AW'((my >> SCALE) * IMG_W + (mx >> SCALE)) : '0;
            fs  = de_rise && (armed || vs_edge);
            armed = (armed || vs_edge) && !fs;
            if (de) mx++;
            if (de_fall) begin mx = 0; my++; end
            if (vs_edge) my = 0;
            prev_de = de;
            prev_vs = vs_act;
            h_de[cyc] = de; h_img[cyc] = img; h_fs[cyc] = fs; h_addr[cyc] = a;
        end

        @(negedge clk);
        if (!rst_n) begin
            chk("rst_addr", 32'(px_addr), 0);
            chk("rst_de", 32'(de_o), 0);
            chk("rst_hs", 32'(hs_o), 1);
            chk("rst_vs", 32'(vs_o), 1);
            chk("rst_rgb", {8'h0, red, green, blue}, 0);
            chk("rst_fs", 32'(fs_o), 0);
        end else begin
            chk("addr", 32'(px_addr), (cyc == 0) ? 32'h0 : 32'(h_addr[cyc-1]));
            s = cyc - LAT;
            if (s < 0 || s <= last_rst) begin
                e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_rgb = '0;
            end else begin
                e_de = h_de[s]; e_hs = h_hs[s]; e_vs = h_vs[s]; e_fs = h_fs[s];
                b = h_addr[s][7:0];
                if (!e_de)          e_rgb = '0;
                else if (h_img[s])  e_rgb = {b, b, b} ^ {24{h_inv[cyc-1]}};
                else                e_rgb = BORDER;
            end
            chk("de", 32'(de_o), 32'(e_de));
            chk("hsync", 32'(hs_o), 32'(e_hs));
            chk("vsync", 32'(vs_o), 32'(e_vs));
            chk("rgb", {8'h0, red, green, blue}, {8'h0, e_rgb});
            chk("frame_start", 32'(fs_o), 32'(e_fs));
        end
        if (fs_o === 1'b1) fs_cnt++;
        if (pend_v) chk(pend_tag, 32'(px_addr), pend_exp);
        pend_v   = spot_v;
        pend_exp = spot_exp;
        pend_tag = spot_tag;
        cyc++;
    endtask

    // One frame of raw timing. variant=1 puts the VS edge on the final DE
    // fall; rst_line>=0 pulses reset mid-line on that line.
    task automatic run_frame(input bit variant, input int rst_line);
        int    hb;
        bit    de, hs, vs_on, r, sv;
        int    se;
        string st;
        for (int line = 0; line < V_TOT; line++) begin
            hb = $urandom_range(8, 14);
            for (int x = 0; x < H_ACT + hb; x++) begin
                de = (line < V_ACT) && (x < H_ACT);
                hs = !((x >= H_ACT + 2) && (x < H_ACT + 6));
                if (variant) vs_on = ((line == V_ACT - 1) && (x >= H_ACT)) || (line == V_ACT);
                else         vs_on = (line == V_ACT + 1) || (line == V_ACT + 2);
                r  = (line == rst_line) && (x >= 50) && (x < 58);
                sv = 0; se = 0; st = "";
                if (line == 0 && x == 2)                     begin sv = 1; se = 1;     st = "line0_px2";  end
                if (line == 1 && x == 2)                     begin sv = 1; se = 1;     st = "line1_px2";  end
                if (line == 2 && x == 0)                     begin sv = 1; se = IMG_W; st = "line2_start"; end
                if (rst_line < 0 && line == 2*IMG_H - 1 && x == 2*IMG_W - 1)
                                                             begin sv = 1; se = IMG_W*IMG_H - 1; st = "last_img_addr"; end
                if (rst_line < 0 && line == 2*IMG_H - 1 && x == H_ACT)
                                                             begin sv = 1; se = 0;     st = "addr_after_de_fall"; end
                drive(r, de, hs, !vs_on, sv, se, st);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "");
        run_frame(1'b0, -1);
        run_frame(1'b1, -1);
        run_frame(1'b0, 30);
        run_frame(1'b0, -1);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, "");
        // Frames 1, 2 and 3 follow a VS edge; frame 0 does not
        chk("frame_start_count", 32'(fs_cnt), 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
